addsub_multicycle: RTL and testbench

Parametrised, multi-cycle two's-complement add/subtract unit. It processes WIDTH-bit operands CHUNK bits per clock through one shared chunk adder. It is the area-reduced, mode-selectable successor to the fixed 32-bit combinational subtractor, and sits on the ALU side of the datapath behind a start/done handshake. It reports unsigned carry (no-borrow on subtract) and signed overflow for the full-width result.

---
 rtl/addsub_multicycle_pkg.sv | 22 ++
 rtl/addsub_multicycle_adder_chunk.sv | 28 ++
 rtl/addsub_multicycle.sv | 124 ++++++++++++
 tb/tb_addsub_multicycle.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_multicycle_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM encodings,
// mode constants and the counter-width helper.
`ifndef ADDSUB_MULTICYCLE_PKG_SV
`define ADDSUB_MULTICYCLE_PKG_SV
package addsub_multicycle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Chunk counter needs at least one bit even when a single chunk covers WIDTH.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`endif

// File: rtl/addsub_multicycle_adder_chunk.sv
// CHUNK-bit ripple adder shared across all cycles of an operation; exposes the
// carry into its top bit so the caller can derive signed overflow.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
      assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (a[gi] & b[gi]) | (a[gi] & w_c[gi]) | (b[gi] & w_c[gi]);
    end
  endgenerate

  assign cout    = w_c[CHUNK];
  assign msb_cin = w_c[CHUNK-1];

endmodule

// File: rtl/addsub_multicycle.sv
// Multi-cycle two's-complement add/subtract: WIDTH-bit operands are consumed
// CHUNK bits per clock through one shared adder behind a start/done handshake.
module addsub_multicycle
  import addsub_multicycle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0]       w_sum;
  logic                   w_cout;
  logic                   w_msb_cin;
  logic [WIDTH+CHUNK-1:0] w_cat;
  logic [WIDTH-1:0]       w_res_shift;
  logic                   w_accept;
  logic                   w_last;

  adder_chunk #(.CHUNK(CHUNK)) u_adder (
    .a       (r_a[CHUNK-1:0]),
    .b       (r_b[CHUNK-1:0]),
    .cin     (r_carry),
    .sum     (w_sum),
    .cout    (w_cout),
    .msb_cin (w_msb_cin)
  );

  // New chunk enters at the top; after N shifts chunk 0 sits at bit 0.
  assign w_cat       = {w_sum, r_res};
  assign w_res_shift = w_cat[WIDTH+CHUNK-1:CHUNK];
  assign w_accept    = (r_state != RUN) && start;
  assign w_last      = (r_state == RUN) && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = RUN;
      end
      RUN: begin
        ready = 1'b0;
        if (r_cnt == LAST) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = start ? RUN : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtract is a + ~b + 1; the +1 rides in on the initial carry.
      r_a     <= in_a;
      r_b     <= (sub == SUB) ? ~in_b : in_b;
      r_carry <= sub;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_res   <= w_res_shift;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_out  <= w_res_shift;
        r_cout <= w_cout;
        r_ovf  <= w_cout ^ w_msb_cin;
      end
    end
  end

  assign out       = r_out;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Scoreboard bench for addsub_multicycle: three instances (CHUNK=8, 32, 1),
// directed vectors with hand-computed results checked by per-instance monitors.
module tb_addsub_multicycle;

  typedef struct packed {
    logic [31:0] o;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sub_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [2:0]  start_v = '0;
  logic [2:0]  ready_v;
  logic [2:0]  done_v;
  logic [2:0]  c_v;
  logic [2:0]  o_v;
  logic [31:0] out_v [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_multicycle #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_i), .in_a(a_i), .in_b(b_i),
    .ready(ready_v[0]), .done(done_v[0]), .out(out_v[0]), .carry_out(c_v[0]), .overflow(o_v[0])
  );
  addsub_multicycle #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_i), .in_a(a_i), .in_b(b_i),
    .ready(ready_v[1]), .done(done_v[1]), .out(out_v[1]), .carry_out(c_v[1]), .overflow(o_v[1])
  );
  addsub_multicycle #(.WIDTH(32), .CHUNK(1)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_i), .in_a(a_i), .in_b(b_i),
    .ready(ready_v[2]), .done(done_v[2]), .out(out_v[2]), .carry_out(c_v[2]), .overflow(o_v[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic score(input int k, input bit have, input exp_t e,
                       input logic [31:0] o, input logic c, input logic v);
    if (!have) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_done dut%0d: got out=0x%08h, expected no completion", k, o);
    end else begin
      $display("[TB] dut%0d done out=0x%08h carry=%0b ovf=%0b (want 0x%08h %0b %0b)",
               k, o, c, v, e.o, e.c, e.v);
      check($sformatf("dut%0d_out", k), o, e.o);
      check($sformatf("dut%0d_carry", k), 32'(c), 32'(e.c));
      check($sformatf("dut%0d_ovf", k), 32'(v), 32'(e.v));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   h;
    if (done_v[0]) begin
      h = (q0.size() > 0);
      e = h ? q0.pop_front() : '0;
      score(0, h, e, out_v[0], c_v[0], o_v[0]);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   h;
    if (done_v[1]) begin
      h = (q1.size() > 0);
      e = h ? q1.pop_front() : '0;
      score(1, h, e, out_v[1], c_v[1], o_v[1]);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   h;
    if (done_v[2]) begin
      h = (q2.size() > 0);
      e = h ? q2.pop_front() : '0;
      score(2, h, e, out_v[2], c_v[2], o_v[2]);
    end
  end

  task automatic push(input int k, input logic [31:0] o, input logic c, input logic v);
    exp_t e;
    e = '{o: o, c: c, v: v};
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Called just after the accepting edge; lat counts edges from it to done visible.
  task automatic wait_done(input int k, input int maxc, input bit keep,
                           output int lat, output int low, output bit got);
    lat = 0;
    low = 0;
    got = 1'b0;
    for (int i = 0; i <= maxc; i++) begin
      @(negedge clk);
      if (done_v[k]) begin
        got = 1'b1;
        lat = i;
        if (!keep) start_v[k] = 1'b0;
      end else if (!ready_v[k]) begin
        low++;
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout dut%0d: got no done, expected one within %0d cycles", k, maxc);
    end
  endtask

  task automatic run_op(input int k, input int n, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eo, input logic ec,
                        input logic ev, input string name);
    int lat;
    int low;
    bit got;
    $display("[TB] issue %s dut%0d sub=%0b a=0x%08h b=0x%08h", name, k, s, a, b);
    check({name, "_ready_pre"}, 32'(ready_v[k]), 32'd1);
    push(k, eo, ec, ev);
    sub_i = s;
    a_i = a;
    b_i = b;
    start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    wait_done(k, n + 4, 1'b0, lat, low, got);
    if (got) begin
      check({name, "_latency"}, 32'(lat), 32'(n));
      check({name, "_ready_low"}, 32'(low), 32'(n));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int low;
    bit got;
    int t1;
    int t2;

    #1;
    check("rst_ready", 32'(ready_v[0]), 32'd1);
    check("rst_done", 32'(done_v[0]), 32'd0);
    check("rst_out", out_v[0], 32'd0);
    check("rst_carry", 32'(c_v[0]), 32'd0);
    check("rst_ovf", 32'(o_v[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(0, 4, 1'b1, 32'd5, 32'd3, 32'h0000_0002, 1'b1, 1'b0, "sub_5_3");
    run_op(0, 4, 1'b1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_3_5");
    run_op(0, 4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b0, "add_max_1");
    run_op(0, 4, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, "add_smax_1");
    run_op(0, 4, 1'b0, 32'h00FF_00FF, 32'h0001_0001, 32'h0100_0100, 1'b0, 1'b0, "add_chunk_carry");
    run_op(0, 4, 1'b1, 32'd1, 32'h8000_0000, 32'h8000_0001, 1'b0, 1'b1, "sub_1_smin");
    run_op(0, 4, 1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_smin_1");

    // Asynchronous reset in the second RUN cycle, away from any edge.
    $display("[TB] issue reset_mid_run dut0 sub=0 a=0x00000011 b=0x00000022");
    sub_i = 1'b0;
    a_i = 32'h11;
    b_i = 32'h22;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(ready_v[0]), 32'd1);
    check("arst_done", 32'(done_v[0]), 32'd0);
    check("arst_out", out_v[0], 32'd0);
    check("arst_carry", 32'(c_v[0]), 32'd0);
    check("arst_ovf", 32'(o_v[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(0, 4, 1'b0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, "add_10_20");

    // A start pulse with new operands during RUN must be ignored.
    $display("[TB] issue ignore_mid_run dut0 sub=0 a=0x00001000 b=0x00000234");
    push(0, 32'h0000_1234, 1'b0, 1'b0);
    sub_i = 1'b0;
    a_i = 32'h1000;
    b_i = 32'h0234;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    @(posedge clk);
    #1;
    start_v[0] = 1'b1;
    sub_i = 1'b1;
    a_i = 32'hFFFF_FFFF;
    b_i = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_done(0, 8, 1'b0, lat, low, got);
    if (got) check("ignore_latency", 32'(lat), 32'd2);

    // Back-to-back: start held through DONE re-enters RUN directly.
    $display("[TB] issue back_to_back dut0 ops=0x11111111+0x22222222, 0x10-0x20");
    push(0, 32'h3333_3333, 1'b0, 1'b0);
    push(0, 32'hFFFF_FFF0, 1'b0, 1'b0);
    sub_i = 1'b0;
    a_i = 32'h1111_1111;
    b_i = 32'h2222_2222;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    sub_i = 1'b1;
    a_i = 32'h10;
    b_i = 32'h20;
    wait_done(0, 8, 1'b1, lat, low, got);
    t1 = cyc;
    if (got) begin
      wait_done(0, 8, 1'b0, lat, low, got);
      t2 = cyc;
      if (got) check("b2b_spacing", 32'(t2 - t1), 32'd5);
    end
    start_v[0] = 1'b0;

    run_op(1, 1, 1'b1, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b1, 1'b0, "c32_sub_eq");
    run_op(2, 32, 1'b1, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b1, 1'b0, "c1_sub_eq");

    @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
